// File: rtl/cdb_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// cdb_arbiter_pkg
// Shared result/tag types for the common data bus and the reservation stations.
//   NUM_FU        - functional units feeding the CDB
//   TAG_W         - producer tag width: {station id[1:0], row[2:0]}
//   DATA_W        - signed result width
//   cdb_tag_t     - producer tag
//   TAG_NONE      - tag value meaning "no producer"
//   cdb_packet_t  - {tag, data} as queued per FU and broadcast on the bus
// -----------------------------------------------------------------------------
package cdb_arbiter_pkg;

  localparam int NUM_FU = 2;
  localparam int TAG_W  = 5;
  localparam int DATA_W = 32;

  typedef logic [TAG_W-1:0] cdb_tag_t;

  localparam cdb_tag_t TAG_NONE = '0;

  typedef struct packed {
    cdb_tag_t                  tag;
    logic signed [DATA_W-1:0]  data;
  } cdb_packet_t;

  // Round-robin successor of a granted index.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1) % n;
  endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// -----------------------------------------------------------------------------
// cdb_arbiter_if
// FU-to-arbiter result handshake plus the broadcast common data bus.
//   fu_valid_in  [NUM_FU]          per-FU result valid
//   fu_tag_in    [NUM_FU][TAG_W]   per-FU producer tag
//   fu_data_in   [NUM_FU][DATA_W]  per-FU signed result
//   fu_ready_out [NUM_FU]          per-FU buffer can accept
//   cdb_valid_out                  broadcast valid this cycle
//   cdb_tag_out / cdb_data_out     broadcast tag / signed result
//   cdb_src_out                    index of the FU being broadcast
// Modports: master = FU / bus-listener side, slave = arbiter side.
// -----------------------------------------------------------------------------
import cdb_arbiter_pkg::*;

interface cdb_arbiter_if #(
  parameter int NUM_FU = cdb_arbiter_pkg::NUM_FU,
  parameter int TAG_W  = cdb_arbiter_pkg::TAG_W,
  parameter int DATA_W = cdb_arbiter_pkg::DATA_W
);
  localparam int SRC_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

  logic [NUM_FU-1:0]             fu_valid_in;
  logic [NUM_FU-1:0][TAG_W-1:0]  fu_tag_in;
  logic [NUM_FU-1:0][DATA_W-1:0] fu_data_in;
  logic [NUM_FU-1:0]             fu_ready_out;
  logic                          cdb_valid_out;
  logic [TAG_W-1:0]              cdb_tag_out;
  logic signed [DATA_W-1:0]      cdb_data_out;
  logic [SRC_W-1:0]              cdb_src_out;

  modport master (
    output fu_valid_in, fu_tag_in, fu_data_in,
    input  fu_ready_out, cdb_valid_out, cdb_tag_out, cdb_data_out, cdb_src_out
  );

  modport slave (
    input  fu_valid_in, fu_tag_in, fu_data_in,
    output fu_ready_out, cdb_valid_out, cdb_tag_out, cdb_data_out, cdb_src_out
  );

endinterface

// File: rtl/cdb_arbiter_result_fifo.sv
// -----------------------------------------------------------------------------
// result_fifo
// DEPTH-entry FIFO of cdb_packet_t for one functional unit.
//   clk, rst_n  clock / asynchronous active-low reset (flushes the queue)
//   i_push      enqueue i_pkt (ignored when full)
//   i_pkt       packet to enqueue
//   i_pop       dequeue head (ignored when empty)
//   o_head      current head packet (valid when o_count != 0)
//   o_count     occupancy 0..DEPTH
// -----------------------------------------------------------------------------
import cdb_arbiter_pkg::*;

module result_fifo #(
  parameter int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_push,
  input  cdb_packet_t       i_pkt,
  input  logic              i_pop,
  output cdb_packet_t       o_head,
  output logic [CNT_W-1:0]  o_count
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  cdb_packet_t       r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              w_do_push;
  logic              w_do_pop;

  // Pointers wrap at DEPTH so non-power-of-two depths stay in range.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // A push while full is dropped even if a pop happens in the same cycle;
  // the producer's ready is based on occupancy alone.
  assign w_do_push = i_push && (r_count != CNT_W'(DEPTH));
  assign w_do_pop  = i_pop  && (r_count != '0);

  // Payload storage carries no reset: occupancy alone says what is valid.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_pkt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_do_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/cdb_arbiter.sv
// -----------------------------------------------------------------------------
// cdb_arbiter
// Buffers results from NUM_FU functional units (one result_fifo each) and
// broadcasts at most one per cycle on the common data bus, round-robin.
//   clk_100mhz  clock, all state on rising edge
//   sys_rst_n   asynchronous active-low reset
//   bus         cdb_arbiter_if.slave: FU inputs, fu_ready_out, cdb_* outputs
// A result pushed at edge k is popped/registered at edge k+1 at the earliest.
// -----------------------------------------------------------------------------
import cdb_arbiter_pkg::*;

module cdb_arbiter #(
  parameter int NUM_FU = cdb_arbiter_pkg::NUM_FU,
  parameter int DEPTH  = 2,
  parameter int DATA_W = cdb_arbiter_pkg::DATA_W,
  parameter int TAG_W  = cdb_arbiter_pkg::TAG_W
) (
  input  logic         clk_100mhz,
  input  logic         sys_rst_n,
  cdb_arbiter_if.slave bus
);
  localparam int SRC_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  cdb_packet_t        w_push_pkt [NUM_FU];
  cdb_packet_t        w_head_pkt [NUM_FU];
  logic [CNT_W-1:0]   w_count    [NUM_FU];
  logic [NUM_FU-1:0]  w_ready;
  logic [NUM_FU-1:0]  w_push;
  logic [NUM_FU-1:0]  w_pop;
  logic               w_grant;
  logic [SRC_W-1:0]   w_grant_idx;
  logic [SRC_W-1:0]   w_cand;

  logic               r_cdb_valid;
  logic [TAG_W-1:0]   r_cdb_tag;
  logic [DATA_W-1:0]  r_cdb_data;
  logic [SRC_W-1:0]   r_cdb_src;
  logic [SRC_W-1:0]   r_rr_ptr;

  for (genvar gi = 0; gi < NUM_FU; gi++) begin : g_fu
    // Ready looks only at registered occupancy (no pop-to-ready path) and is
    // forced low while reset is asserted.
    assign w_ready[gi] = (w_count[gi] < CNT_W'(DEPTH)) && sys_rst_n;
    // Tag 0 carries no producer: silently discarded.
    assign w_push[gi]  = bus.fu_valid_in[gi] && w_ready[gi] &&
                         (bus.fu_tag_in[gi] != TAG_NONE);
    assign w_push_pkt[gi].tag  = bus.fu_tag_in[gi];
    assign w_push_pkt[gi].data = bus.fu_data_in[gi];

    result_fifo #(
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk     (clk_100mhz),
      .rst_n   (sys_rst_n),
      .i_push  (w_push[gi]),
      .i_pkt   (w_push_pkt[gi]),
      .i_pop   (w_pop[gi]),
      .o_head  (w_head_pkt[gi]),
      .o_count (w_count[gi])
    );
  end

  // Scan FUs starting at r_rr_ptr; the first non-empty one wins.
  always_comb begin
    w_grant     = 1'b0;
    w_grant_idx = '0;
    w_cand      = '0;
    w_pop       = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      w_cand = SRC_W'((int'(r_rr_ptr) + k) % NUM_FU);
      if (!w_grant && (w_count[w_cand] != '0)) begin
        w_grant     = 1'b1;
        w_grant_idx = w_cand;
      end
    end
    if (w_grant) begin
      w_pop[w_grant_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk_100mhz or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_rr_ptr    <= '0;
      r_cdb_valid <= 1'b0;
      r_cdb_tag   <= '0;
      r_cdb_data  <= '0;
      r_cdb_src   <= '0;
    end else begin
      r_cdb_valid <= w_grant;
      if (w_grant) begin
        r_cdb_tag  <= w_head_pkt[w_grant_idx].tag;
        r_cdb_data <= w_head_pkt[w_grant_idx].data;
        r_cdb_src  <= w_grant_idx;
        r_rr_ptr   <= SRC_W'(rr_next(int'(w_grant_idx), NUM_FU));
      end else begin
        // Idle bus is driven to all zeros.
        r_cdb_tag  <= '0;
        r_cdb_data <= '0;
        r_cdb_src  <= '0;
      end
    end
  end

  assign bus.fu_ready_out  = w_ready;
  assign bus.cdb_valid_out = r_cdb_valid;
  assign bus.cdb_tag_out   = r_cdb_tag;
  assign bus.cdb_data_out  = r_cdb_data;
  assign bus.cdb_src_out   = r_cdb_src;

endmodule

// File: tb/tb_cdb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cdb_arbiter
// Directed scenarios followed by random traffic, checked against a queue-based
// reference model of the per-FU buffers and round-robin broadcast.
// -----------------------------------------------------------------------------
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  localparam int NF = 2;
  localparam int DP = 2;
  localparam int DW = 32;
  localparam int TW = 5;

  logic clk_100mhz = 1'b0;
  logic sys_rst_n  = 1'b0;

  always #5 clk_100mhz = ~clk_100mhz;

  cdb_arbiter_if #(.NUM_FU(NF), .TAG_W(TW), .DATA_W(DW)) bus ();

  cdb_arbiter #(
    .NUM_FU (NF),
    .DEPTH  (DP),
    .DATA_W (DW),
    .TAG_W  (TW)
  ) dut (
    .clk_100mhz (clk_100mhz),
    .sys_rst_n  (sys_rst_n),
    .bus        (bus.slave)
  );

  // Reference model: pending results per FU, round-robin pointer, and the
  // broadcast expected to be visible after the next rising edge.
  logic [TW+DW-1:0] mq [NF][$];
  int               m_rr;
  logic             e_valid;
  logic [TW-1:0]    e_tag;
  logic [DW-1:0]    e_data;
  int               e_src;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic check_outputs(input string ctx);
    logic [NF-1:0] e_ready;
    for (int i = 0; i < NF; i++) e_ready[i] = sys_rst_n && (mq[i].size() < DP);
    check_eq({ctx, ".ready"}, 64'(bus.fu_ready_out), 64'(e_ready));
    check_eq({ctx, ".valid"}, 64'(bus.cdb_valid_out), 64'(e_valid));
    check_eq({ctx, ".tag"},   64'(bus.cdb_tag_out), e_valid ? 64'(e_tag) : 64'(0));
    check_eq({ctx, ".data"},  64'($unsigned(bus.cdb_data_out)), e_valid ? 64'(e_data) : 64'(0));
    check_eq({ctx, ".src"},   64'(bus.cdb_src_out), e_valid ? 64'(e_src) : 64'(0));
    if (bus.cdb_valid_out === 1'b1)
      $display("bcast t=%0t src=%0d tag=%02h data=%08h", $time, bus.cdb_src_out,
               bus.cdb_tag_out, $unsigned(bus.cdb_data_out));
  endtask

  // Apply the rules for the coming rising edge to the model, using the inputs
  // currently driven.
  task automatic model_step();
    bit [NF-1:0] rdy;
    bit          granted;
    int          idx;
    granted = 1'b0;
    e_valid = 1'b0;
    e_tag   = '0;
    e_data  = '0;
    e_src   = 0;
    for (int i = 0; i < NF; i++) rdy[i] = (mq[i].size() < DP);
    for (int k = 0; k < NF; k++) begin
      idx = (m_rr + k) % NF;
      if (!granted && mq[idx].size() > 0) begin
        granted          = 1'b1;
        {e_tag, e_data}  = mq[idx].pop_front();
        e_valid          = 1'b1;
        e_src            = idx;
        m_rr             = (idx + 1) % NF;
      end
    end
    for (int i = 0; i < NF; i++)
      if (bus.fu_valid_in[i] && rdy[i] && bus.fu_tag_in[i] != '0)
        mq[i].push_back({bus.fu_tag_in[i], bus.fu_data_in[i]});
  endtask

  // One clock: check outputs at the falling edge, drive new inputs, advance model.
  task automatic cycle(input string ctx, input logic [NF-1:0] v,
                       input logic [TW-1:0] t0, input logic [DW-1:0] d0,
                       input logic [TW-1:0] t1, input logic [DW-1:0] d1);
    @(negedge clk_100mhz);
    check_outputs(ctx);
    bus.fu_valid_in   = v;
    bus.fu_tag_in[0]  = t0;
    bus.fu_data_in[0] = d0;
    bus.fu_tag_in[1]  = t1;
    bus.fu_data_in[1] = d1;
    model_step();
  endtask

  task automatic idle(input string ctx);
    cycle(ctx, 2'b00, '0, '0, '0, '0);
  endtask

  initial begin
    logic [TW-1:0] rt0, rt1;
    bus.fu_valid_in = '0;
    bus.fu_tag_in   = '0;
    bus.fu_data_in  = '0;
    m_rr    = 0;
    e_valid = 1'b0;
    e_tag   = '0;
    e_data  = '0;
    e_src   = 0;

    // Reset state
    repeat (3) @(posedge clk_100mhz);
    @(negedge clk_100mhz);
    check_outputs("reset");
    @(posedge clk_100mhz);
    #2 sys_rst_n = 1'b1;

    // Simultaneous push from both FUs with rr_ptr = 0
    cycle("t34", 2'b11, 5'h09, 32'd7, 5'h11, 32'hFFFF_FFFD);
    idle("t34");
    idle("t34");
    check_eq("t34.first_src", 64'(bus.cdb_src_out), 64'(0));
    check_eq("t34.first_tag", 64'(bus.cdb_tag_out), 64'(5'h09));
    idle("t34");
    check_eq("t34.second_src",  64'(bus.cdb_src_out), 64'(1));
    check_eq("t34.second_data", 64'($unsigned(bus.cdb_data_out)), 64'(32'hFFFF_FFFD));
    idle("t34");

    // Two-edge latency, single FU0 result
    cycle("t33", 2'b01, 5'b01_010, 32'hDEAD_BEEF, '0, '0);
    idle("t33");
    check_eq("t33.early_valid", 64'(bus.cdb_valid_out), 64'(0));
    idle("t33");
    check_eq("t33.valid", 64'(bus.cdb_valid_out), 64'(1));
    check_eq("t33.tag",   64'(bus.cdb_tag_out), 64'(5'b01_010));
    check_eq("t33.data",  64'($unsigned(bus.cdb_data_out)), 64'(32'hDEAD_BEEF));
    check_eq("t33.src",   64'(bus.cdb_src_out), 64'(0));
    idle("t33");
    check_eq("t33.once", 64'(bus.cdb_valid_out), 64'(0));

    // Tag 0 is discarded
    cycle("t36", 2'b01, '0, 32'd42, '0, '0);
    idle("t36");
    check_eq("t36.ready0", 64'(bus.fu_ready_out[0]), 64'(1));
    idle("t36");
    check_eq("t36.valid", 64'(bus.cdb_valid_out), 64'(0));

    // FU1 sole producer for three cycles
    for (int n = 0; n < 6; n++) begin
      if (n < 3) cycle("t38", 2'b10, '0, '0, TW'(5'h0A + n), DW'(100 + n));
      else       idle("t38");
      if (n >= 2 && n <= 4) begin
        check_eq("t38.valid", 64'(bus.cdb_valid_out), 64'(1));
        check_eq("t38.tag",   64'(bus.cdb_tag_out), 64'(5'h0A + n - 2));
        check_eq("t38.src",   64'(bus.cdb_src_out), 64'(1));
      end
    end
    idle("t38");

    // Both FUs push every cycle for six cycles
    for (int n = 0; n < 6; n++) begin
      cycle("t35", 2'b11, TW'(n + 1), DW'(200 + n), TW'(n + 17), DW'(300 + n));
      if (n >= 2) check_eq("t35.src", 64'(bus.cdb_src_out), 64'((n - 2) % 2));
      if (n == 3) check_eq("t35.ready_e3", 64'(bus.fu_ready_out), 64'(2'b10));
      if (n == 4) check_eq("t35.ready_e4", 64'(bus.fu_ready_out), 64'(2'b01));
    end
    repeat (8) idle("t35");

    // Reset mid-operation drops queued results
    cycle("t37", 2'b11, 5'h03, 32'd1, 5'h04, 32'd2);
    idle("t37");
    idle("t37");
    #2 sys_rst_n = 1'b0;
    #1;
    for (int i = 0; i < NF; i++) mq[i].delete();
    m_rr    = 0;
    e_valid = 1'b0;
    check_outputs("t37.rst");
    check_eq("t37.rst_valid", 64'(bus.cdb_valid_out), 64'(0));
    @(posedge clk_100mhz);
    #2 sys_rst_n = 1'b1;
    for (int n = 0; n < 4; n++) begin
      idle("t37.post");
      check_eq("t37.post_valid", 64'(bus.cdb_valid_out), 64'(0));
    end

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      rt0 = ($urandom_range(0, 7) == 0) ? TW'(0) : TW'($urandom_range(1, 31));
      rt1 = ($urandom_range(0, 7) == 0) ? TW'(0) : TW'($urandom_range(1, 31));
      cycle("rand", NF'($urandom_range(0, 3)), rt0, DW'($urandom), rt1, DW'($urandom));
    end
    repeat (8) idle("drain");
    @(negedge clk_100mhz);
    check_outputs("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
